// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the sequential priority encoder.
package encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n request lines; never below one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational find-first-set over N bits, starting at base and walking
// upward (dir_down=0) or downward (dir_down=1) with wrap-around.
module prio_find
  import encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] base,
  input  logic         dir_down,
  output logic         found,
  output logic [W-1:0] idx
);

  int pos;

  // Walk from the farthest offset inward so the nearest set bit wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = dir_down ? (int'(base) - k) : (int'(base) + k);
      if (pos < 0)
        pos = pos + N;
      else if (pos >= N)
        pos = pos - N;
      if (vec[W'(pos)]) begin
        found = 1'b1;
        idx   = W'(pos);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_seq.sv
// Captures request bits into a pending set and issues one encoded index per
// cycle, with fixed-priority or round-robin selection and output backpressure.
module priority_encoder_seq
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = idx_width(N),
  parameter int ARB_MODE  = MODE_FIXED,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         req_valid,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow,
  output logic         empty
);

  logic [W-1:0] rr_ptr;
  logic [W-1:0] base;
  logic         dir_down;
  logic         found;
  logic [W-1:0] sel;
  logic         issue;
  logic [N-1:0] issue_mask;
  logic [N-1:0] kept;
  logic [N-1:0] captured;

  generate
    if (ARB_MODE == MODE_RR) begin : g_rr
      assign base     = (rr_ptr == W'(N - 1)) ? '0 : rr_ptr + 1'b1;
      assign dir_down = 1'b0;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign base     = W'(N - 1);
      assign dir_down = 1'b1;
    end else begin : g_lsb
      assign base     = '0;
      assign dir_down = 1'b0;
    end
  endgenerate

  prio_find #(.N(N), .W(W)) u_find (
    .vec      (pending),
    .base     (base),
    .dir_down (dir_down),
    .found    (found),
    .idx      (sel)
  );

  // Selection only sees pending from before the edge; same-edge captures wait.
  assign issue = found && (!out_valid || out_ready);

  always_comb begin
    issue_mask = '0;
    if (issue)
      issue_mask[sel] = 1'b1;
  end

  assign kept     = pending & ~issue_mask;
  assign captured = req_valid ? req_in : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      rr_ptr    <= W'(N - 1);
    end else begin
      // A bit issued and re-captured at the same edge is a fresh request.
      pending  <= kept | captured;
      overflow <= |(captured & kept);
      if (issue) begin
        out_idx   <= sel;
        out_valid <= 1'b1;
        rr_ptr    <= sel;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign empty = (pending == '0) && !out_valid;

endmodule
